// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer and its opcode decoder.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CB_FETCH,
    ST_OPERAND,
    ST_EXECUTE,
    ST_STORE
  } state_t;

  // Bit positions inside the ALU function-control word
  localparam logic [2:0] FC_MAIN  = 3'd0;
  localparam logic [2:0] FC_INC   = 3'd1;
  localparam logic [2:0] FC_DEC   = 3'd2;
  localparam logic [2:0] FC_LOGIC = 3'd3;
  localparam logic [2:0] FC_NOZ   = 3'd4;
  localparam logic [2:0] FC_MISC  = 3'd5;

  // Register field encodings that are not register-file entries
  localparam logic [2:0] REG_HL_IND = 3'd6;
  localparam logic [2:0] REG_A      = 3'd7;

  localparam logic [7:0] OP_CB_PREFIX = 8'hCB;

  // ALU register select values
  localparam logic [1:0] ALU_SEL_NONE = 2'b00;
  localparam logic [1:0] ALU_SEL_A    = 2'b01;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_MAIN,
    CLS_INCDEC,
    CLS_LOGIC,
    CLS_MISC,
    CLS_PREFIX,
    CLS_CB
  } op_class_t;

  typedef enum logic [1:0] {
    DEST_NONE,
    DEST_A,
    DEST_REG,
    DEST_MEM
  } dest_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier: first byte or CB second byte in,
// class / function control / operand source / destination out.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [7:0] i_Byte,
  input  logic       i_Is_Cb,
  output op_class_t  o_Class,
  output logic [5:0] o_Function_Control,
  output logic [2:0] o_Source,
  output dest_t      o_Dest,
  output logic       o_Need_Operand,
  output logic       o_Operand_Kind
);

  // Classify the byte and derive everything the sequencer needs from it
  always_comb begin
    o_Class            = CLS_NONE;
    o_Function_Control = '0;
    o_Source           = i_Byte[2:0];
    o_Dest             = DEST_NONE;
    o_Need_Operand     = 1'b0;
    o_Operand_Kind     = 1'b0;
    if (i_Is_Cb) begin
      o_Class                      = CLS_CB;
      o_Function_Control[FC_LOGIC] = 1'b1;
      o_Need_Operand               = (o_Source == REG_HL_IND);
      o_Operand_Kind               = o_Need_Operand;
      // BIT tests only flags; everything else writes its operand back
      if (i_Byte[7:6] == 2'b01)          o_Dest = DEST_NONE;
      else if (o_Source == REG_HL_IND)   o_Dest = DEST_MEM;
      else if (o_Source == REG_A)        o_Dest = DEST_A;
      else                               o_Dest = DEST_REG;
    end else if (i_Byte == OP_CB_PREFIX) begin
      o_Class = CLS_PREFIX;
    end else if (i_Byte[7:6] == 2'b10) begin
      o_Class                     = CLS_MAIN;
      o_Function_Control[FC_MAIN] = 1'b1;
      o_Need_Operand              = (o_Source == REG_HL_IND);
      o_Operand_Kind              = o_Need_Operand;
      o_Dest                      = (i_Byte[5:3] == 3'b111) ? DEST_NONE : DEST_A;
    end else if (i_Byte[7:6] == 2'b11 && i_Byte[2:0] == 3'b110) begin
      o_Class                     = CLS_MAIN;
      o_Function_Control[FC_MAIN] = 1'b1;
      o_Need_Operand              = 1'b1;
      o_Dest                      = (i_Byte[5:3] == 3'b111) ? DEST_NONE : DEST_A;
    end else if (i_Byte[7:6] == 2'b00 && i_Byte[2:1] == 2'b10) begin
      o_Class                     = CLS_INCDEC;
      o_Source                    = i_Byte[5:3];
      o_Function_Control[FC_INC]  = 1'b1;
      o_Function_Control[FC_DEC]  = i_Byte[0];
      o_Need_Operand              = (o_Source == REG_HL_IND);
      o_Operand_Kind              = o_Need_Operand;
      if (o_Source == REG_HL_IND)  o_Dest = DEST_MEM;
      else if (o_Source == REG_A)  o_Dest = DEST_A;
      else                         o_Dest = DEST_REG;
    end else if (i_Byte[7:5] == 3'b000 && i_Byte[2:0] == 3'b111) begin
      o_Class                      = CLS_LOGIC;
      o_Function_Control[FC_LOGIC] = 1'b1;
      o_Function_Control[FC_NOZ]   = 1'b1;
      o_Source                     = REG_A;
      o_Dest                       = DEST_A;
    end else if (i_Byte[7:5] == 3'b001 && i_Byte[2:0] == 3'b111) begin
      o_Class                     = CLS_MISC;
      o_Function_Control[FC_MISC] = 1'b1;
      o_Source                    = REG_A;
      o_Dest                      = DEST_A;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller that gathers operands, strobes the ALU for one
// enabled cycle and writes the result to A, the register file or memory.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Opcode_Valid,
  output logic       o_Opcode_Ready,
  input  logic [7:0] i_Opcode,
  output logic       o_Operand_Req,
  output logic       o_Operand_Kind,
  input  logic       i_Operand_Valid,
  input  logic [7:0] i_Operand,
  output logic       o_Store_Valid,
  input  logic       i_Store_Ready,
  output logic [7:0] o_Store_Data,
  output logic [2:0] o_Reg_Select,
  input  logic [7:0] i_Reg_Data,
  output logic       o_Reg_Write,
  output logic       o_ALU_Enable,
  output logic [1:0] o_ALU_Read,
  output logic [1:0] o_ALU_Write,
  output logic [7:0] o_ALU_Opcode,
  output logic [7:0] o_ALU_Parameter,
  output logic [5:0] o_ALU_Function_Control,
  output logic       o_ALU_Save_Flags,
  input  logic [7:0] i_ALU_Reg_Data,
  input  logic [7:0] i_ALU_Result,
  output logic       o_Busy,
  output logic       o_Unsupported
);

  state_t     r_State;
  state_t     w_Next;
  logic [7:0] r_Opcode;
  logic [7:0] r_Cb_Byte;
  logic [7:0] r_Operand;
  logic [7:0] r_Result;
  logic       r_Is_Cb;
  logic       r_Unsupported;

  logic [7:0] w_Dec_Byte;
  logic       w_Dec_Cb;
  op_class_t  w_Class;
  logic [5:0] w_Fc;
  logic [2:0] w_Src;
  dest_t      w_Dest;
  logic       w_Need;
  logic       w_Kind;

  // Decoder input: live opcode in IDLE, live CB byte while fetching it,
  // otherwise the latched byte that actually drives the ALU
  always_comb begin
    w_Dec_Byte = r_Is_Cb ? r_Cb_Byte : r_Opcode;
    w_Dec_Cb   = r_Is_Cb;
    if (r_State == ST_IDLE) begin
      w_Dec_Byte = i_Opcode;
      w_Dec_Cb   = 1'b0;
    end else if (r_State == ST_CB_FETCH) begin
      w_Dec_Byte = i_Operand;
      w_Dec_Cb   = 1'b1;
    end
  end

  alu_seq_decode u_decode (
    .i_Byte             (w_Dec_Byte),
    .i_Is_Cb            (w_Dec_Cb),
    .o_Class            (w_Class),
    .o_Function_Control (w_Fc),
    .o_Source           (w_Src),
    .o_Dest             (w_Dest),
    .o_Need_Operand     (w_Need),
    .o_Operand_Kind     (w_Kind)
  );

  // State register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_State <= ST_IDLE;
    else         r_State <= w_Next;
  end

  // Opcode, operand and result latches plus the unsupported pulse
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Opcode      <= '0;
      r_Cb_Byte     <= '0;
      r_Operand     <= '0;
      r_Result      <= '0;
      r_Is_Cb       <= 1'b0;
      r_Unsupported <= 1'b0;
    end else begin
      r_Unsupported <= 1'b0;
      case (r_State)
        ST_IDLE: if (i_Opcode_Valid) begin
          r_Opcode      <= i_Opcode;
          r_Is_Cb       <= (w_Class == CLS_PREFIX);
          r_Unsupported <= (w_Class == CLS_NONE);
        end
        ST_CB_FETCH: if (i_Operand_Valid) r_Cb_Byte <= i_Operand;
        ST_OPERAND:  if (i_Operand_Valid) r_Operand <= i_Operand;
        ST_EXECUTE:  if (w_Dest == DEST_MEM) r_Result <= i_ALU_Result;
        default: ;
      endcase
    end
  end

  // Next-state and strobe generation
  always_comb begin
    w_Next                 = r_State;
    o_Operand_Req          = 1'b0;
    o_Operand_Kind         = 1'b0;
    o_Store_Valid          = 1'b0;
    o_Reg_Select           = '0;
    o_Reg_Write            = 1'b0;
    o_ALU_Enable           = 1'b0;
    o_ALU_Read             = ALU_SEL_NONE;
    o_ALU_Write            = ALU_SEL_NONE;
    o_ALU_Opcode           = '0;
    o_ALU_Parameter        = '0;
    o_ALU_Function_Control = '0;
    o_ALU_Save_Flags       = 1'b0;
    case (r_State)
      ST_IDLE: if (i_Opcode_Valid) begin
        if (w_Class == CLS_NONE)        w_Next = ST_IDLE;
        else if (w_Class == CLS_PREFIX) w_Next = ST_CB_FETCH;
        else if (w_Need)                w_Next = ST_OPERAND;
        else                            w_Next = ST_EXECUTE;
      end
      ST_CB_FETCH: begin
        o_Operand_Req = 1'b1;
        if (i_Operand_Valid) w_Next = w_Need ? ST_OPERAND : ST_EXECUTE;
      end
      ST_OPERAND: begin
        o_Operand_Req  = 1'b1;
        o_Operand_Kind = w_Kind;
        if (i_Operand_Valid) w_Next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        o_ALU_Enable           = 1'b1;
        o_ALU_Read             = ALU_SEL_A;
        o_ALU_Save_Flags       = 1'b1;
        o_ALU_Opcode           = w_Dec_Byte;
        o_ALU_Function_Control = w_Fc;
        o_Reg_Select           = w_Src;
        if (w_Src == REG_A)           o_ALU_Parameter = i_ALU_Reg_Data;
        else if (w_Src == REG_HL_IND) o_ALU_Parameter = r_Operand;
        else                          o_ALU_Parameter = i_Reg_Data;
        w_Next = ST_IDLE;
        case (w_Dest)
          DEST_A:   o_ALU_Write = ALU_SEL_A;
          DEST_REG: o_Reg_Write = 1'b1;
          DEST_MEM: w_Next      = ST_STORE;
          default: ;
        endcase
      end
      ST_STORE: begin
        o_Store_Valid = 1'b1;
        if (i_Store_Ready) w_Next = ST_IDLE;
      end
      default: w_Next = ST_IDLE;
    endcase
  end

  assign o_Opcode_Ready = (r_State == ST_IDLE);
  assign o_Busy         = (r_State != ST_IDLE);
  assign o_Store_Data   = r_Result;
  assign o_Unsupported  = r_Unsupported;

endmodule
